// File: rtl/uart_pkg.sv
// Shared encodings and timing helper for the oversampling UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Centre tick of a bit period; the vote window is MID-1..MID+1.
   function automatic int mid_of(input int ratio);
      return ratio / 2 - 1;
   endfunction

endpackage

// File: rtl/din_sync.sv
// Two-flop synchroniser for the raw serial line; resets to the idle (high) level.
// Latency 2 cycles; no backpressure.
module din_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: start validation, 3-sample mid-bit vote, parity/stop checks.
// Outputs registered; word appears one cycle after the last stop-bit decision; no backpressure.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int SAMPLE_RATIO = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 sample_clk,
   input  logic                 rst,
   input  logic                 din,
   output logic                 sample_sig,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(SAMPLE_RATIO);
   localparam int IDX_W = 4;
   localparam logic [CNT_W-1:0] MID_M1  = CNT_W'(mid_of(SAMPLE_RATIO) - 1);
   localparam logic [CNT_W-1:0] MID_C   = CNT_W'(mid_of(SAMPLE_RATIO));
   localparam logic [CNT_W-1:0] MID_P1  = CNT_W'(mid_of(SAMPLE_RATIO) + 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SAMPLE_RATIO - 1);
   localparam logic [IDX_W-1:0] DATA_TOP = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_TOP = IDX_W'(STOP_BITS - 1);

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 v0_q, v1_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 perr_q, ferr_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 ss_q, dv_q, fe_q, pe_q, busy_q;

   logic s;
   logic vote;
   logic decide;
   logic wrap;
   logic [CNT_W-1:0] cnt_step;

   din_sync u_sync (
      .clk_i (sample_clk),
      .rst_i (rst),
      .d_i   (din),
      .q_o   (s)
   );

   assign vote     = (v0_q & v1_q) | (v0_q & s) | (v1_q & s);
   assign decide   = (cnt_q == MID_P1);
   assign wrap     = (cnt_q == CNT_TOP);
   assign cnt_step = wrap ? '0 : cnt_q + 1'b1;

   always_ff @(posedge sample_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         ss_q    <= 1'b0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ss_q <= 1'b0;
         dv_q <= 1'b0;
         fe_q <= 1'b0;
         pe_q <= 1'b0;
         if (cnt_q == MID_M1) v0_q <= s;
         if (cnt_q == MID_C)  v1_q <= s;

         case (state_q)
            ST_IDLE: begin
               if (!s) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  ferr_q  <= 1'b0;
                  perr_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (decide && vote) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_step;
                  if (wrap) begin
                     state_q <= ST_DATA;
                     idx_q   <= '0;
                  end
               end
            end
            ST_DATA: begin
               cnt_q <= cnt_step;
               if (decide) begin
                  shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
                  ss_q    <= 1'b1;
               end
               if (wrap) begin
                  if (idx_q == DATA_TOP) begin
                     idx_q   <= '0;
                     state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               cnt_q <= cnt_step;
               if (decide) perr_q <= ((^shreg_q) ^ vote) != (PARITY == PAR_ODD);
               if (wrap) begin
                  state_q <= ST_STOP;
                  idx_q   <= '0;
               end
            end
            ST_STOP: begin
               if (decide && idx_q == STOP_TOP) begin
                  // Leave at mid-stop so a back-to-back start edge is not missed.
                  data_q  <= shreg_q;
                  dv_q    <= 1'b1;
                  fe_q    <= ferr_q | ~vote;
                  pe_q    <= perr_q;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  if (ferr_q | ~vote) begin
                     state_q <= ST_BREAK;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_step;
                  if (decide) ferr_q <= ferr_q | ~vote;
                  if (wrap) idx_q <= idx_q + 1'b1;
               end
            end
            ST_BREAK: begin
               if (s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               idx_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sample_sig = ss_q;
   assign data       = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;
   assign parity_err = pe_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 8N1 instance and 8E1 instance, frame-level model plus literal checks.
module tb_uart_rx_sampler;

   localparam int SR  = 16;
   localparam int DEC = SR / 2 + 3;   // output edge offset from bit start: mid vote + sync + register

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } dv_t;

   logic clk, rst, din0, din1;
   logic ss0, dv0, fe0, pe0, busy0;
   logic ss1, dv1, fe1, pe1, busy1;
   logic [7:0] data0, data1;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   bit  exp_ss [int];
   bit  exp_bz [int];
   dv_t exp_dv [int];
   logic [7:0] data_model [2];

   int ss_cnt0 = 0, dv_cnt0 = 0, last_ss = -1, ss_min = 0, ss_max = 0;
   int last_dv_edge = 0, prev_dv_edge = 0;
   logic [7:0] last_data0 = 0, prev_data0 = 0, last_data1 = 0;
   logic last_fe0 = 0, last_pe0 = 0, last_pe1 = 0, busy_at_dv0 = 1;

   uart_rx_sampler #(.SAMPLE_RATIO(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
      .sample_clk(clk), .rst(rst), .din(din0), .sample_sig(ss0), .data(data0),
      .data_valid(dv0), .frame_err(fe0), .parity_err(pe0), .busy(busy0));

   uart_rx_sampler #(.SAMPLE_RATIO(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
      .sample_clk(clk), .rst(rst), .din(din1), .sample_sig(ss1), .data(data1),
      .data_valid(dv1), .frame_err(fe1), .parity_err(pe1), .busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", name, i, cyc, act, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic ss, input logic dv, input logic [7:0] d,
                             input logic fe, input logic pe, input logic bz);
      int key;
      dv_t e;
      logic e_dv;
      key  = cyc * 2 + i;
      e    = '0;
      e_dv = 1'b0;
      if (exp_dv.exists(key)) begin
         e    = exp_dv[key];
         e_dv = 1'b1;
         data_model[i] = e.d;
      end
      if (rst) data_model[i] = 8'h00;
      cmp("sample_sig", i, 32'(ss), 32'(exp_ss.exists(key)));
      cmp("data_valid", i, 32'(dv), 32'(e_dv));
      cmp("data", i, 32'(d), 32'(data_model[i]));
      cmp("frame_err", i, 32'(fe), 32'(e.fe));
      cmp("parity_err", i, 32'(pe), 32'(e.pe));
      cmp("busy", i, 32'(bz), 32'(exp_bz.exists(key)));
   endtask

   always @(posedge clk) begin
      #1;
      check_inst(0, ss0, dv0, data0, fe0, pe0, busy0);
      check_inst(1, ss1, dv1, data1, fe1, pe1, busy1);
      if (ss0) begin
         ss_cnt0++;
         if (last_ss >= 0) begin
            if (cyc - last_ss < ss_min) ss_min = cyc - last_ss;
            if (cyc - last_ss > ss_max) ss_max = cyc - last_ss;
         end
         last_ss = cyc;
      end
      if (dv0) begin
         dv_cnt0++;
         prev_dv_edge = last_dv_edge;
         last_dv_edge = cyc;
         prev_data0   = last_data0;
         last_data0   = data0;
         last_fe0     = fe0;
         last_pe0     = pe0;
         busy_at_dv0  = busy0;
      end
      if (dv1) begin
         last_data1 = data1;
         last_pe1   = pe1;
      end
   end

   function automatic void clear_future(input int from_key);
      int ks[$];
      foreach (exp_ss[k]) if (k >= from_key) ks.push_back(k);
      foreach (ks[j]) exp_ss.delete(ks[j]);
      ks.delete();
      foreach (exp_bz[k]) if (k >= from_key) ks.push_back(k);
      foreach (ks[j]) exp_bz.delete(ks[j]);
      ks.delete();
      foreach (exp_dv[k]) if (k >= from_key) ks.push_back(k);
      foreach (ks[j]) exp_dv.delete(ks[j]);
   endfunction

   task automatic drive(input int i, input logic v);
      if (i == 0) din0 = v;
      else        din1 = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge. Bit b of the frame occupies line edges k+SR*b .. k+SR*b+SR-1.
   task automatic send_frame(input int i, input logic [7:0] d, input logic pbit, input logic stopv,
                             input int hold, input int gbit, input int abort_t);
      logic bits[$];
      int k, nbits, dv_edge, busy_end;
      dv_t e;
      k = cyc + 1;
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(d[j]);
      if (i == 1) bits.push_back(pbit);
      bits.push_back(stopv);
      nbits = bits.size();

      for (int b = 1; b <= 8; b++) exp_ss[(k + DEC + SR * b) * 2 + i] = 1'b1;
      dv_edge = k + DEC + SR * (nbits - 1);
      e.d  = d;
      e.fe = ~stopv;
      e.pe = (i == 1) ? ((^d) ^ pbit) : 1'b0;
      exp_dv[dv_edge * 2 + i] = e;
      busy_end = stopv ? dv_edge - 1 : k + SR * nbits + hold + 1;
      for (int ed = k + 2; ed <= busy_end; ed++) exp_bz[ed * 2 + i] = 1'b1;

      for (int t = 0; t < nbits * SR; t++) begin
         if (t == abort_t) begin
            drive(i, 1'b1);
            rst = 1'b1;
            clear_future((cyc + 1) * 2);
            #1;
            cmp("rst_ss_now", i, 32'(ss0), 32'd0);
            cmp("rst_busy_now", i, 32'(busy0), 32'd0);
            cmp("rst_data_now", i, 32'(data0), 32'h00);
            idle(3);
            rst = 1'b0;
            return;
         end
         drive(i, (t == SR * (gbit + 1) + SR / 2) ? 1'b0 : bits[t / SR]);
         @(negedge clk);
      end
      for (int t = 0; t < hold; t++) begin
         drive(i, 1'b0);
         @(negedge clk);
      end
      drive(i, 1'b1);
   endtask

   task automatic glitch_start(input int i);
      int k;
      k = cyc + 1;
      for (int ed = k + 2; ed <= k + DEC - 1; ed++) exp_bz[ed * 2 + i] = 1'b1;
      drive(i, 1'b0);
      idle(3);
      drive(i, 1'b1);
   endtask

   initial begin
      int base_ss, base_dv;
      rst = 1'b1; din0 = 1'b1; din1 = 1'b1;
      data_model[0] = 8'h00; data_model[1] = 8'h00;
      idle(3);
      cmp("reset_data", 0, 32'(data0), 32'h00);
      cmp("reset_busy", 0, 32'(busy0), 32'd0);
      cmp("reset_dv", 1, 32'(dv1), 32'd0);
      rst = 1'b0;
      idle(5);

      // 8N1 0xA5: eight sample pulses 16 apart, clean word, busy drops with data_valid
      ss_min = 1000; ss_max = 0; last_ss = -1; base_ss = ss_cnt0;
      send_frame(0, 8'hA5, 1'b0, 1'b1, 0, -1, -1);
      idle(20);
      cmp("a5_ss_count", 0, 32'(ss_cnt0 - base_ss), 32'd8);
      cmp("a5_ss_min", 0, 32'(ss_min), 32'd16);
      cmp("a5_ss_max", 0, 32'(ss_max), 32'd16);
      cmp("a5_data", 0, 32'(last_data0), 32'hA5);
      cmp("a5_fe_pe", 0, 32'({last_fe0, last_pe0}), 32'd0);
      cmp("a5_busy_at_dv", 0, 32'(busy_at_dv0), 32'd0);

      // false start
      base_ss = ss_cnt0; base_dv = dv_cnt0;
      glitch_start(0);
      idle(30);
      cmp("glitch_no_ss", 0, 32'(ss_cnt0 - base_ss), 32'd0);
      cmp("glitch_no_dv", 0, 32'(dv_cnt0 - base_dv), 32'd0);

      // even parity: 0x3C has four ones
      send_frame(1, 8'h3C, 1'b1, 1'b1, 0, -1, -1);
      idle(20);
      cmp("par1_data", 1, 32'(last_data1), 32'h3C);
      cmp("par1_err", 1, 32'(last_pe1), 32'd1);
      send_frame(1, 8'h3C, 1'b0, 1'b1, 0, -1, -1);
      idle(20);
      cmp("par0_err", 1, 32'(last_pe1), 32'd0);

      // stop bit low then line held low: frame error, then break until line idles
      base_dv = dv_cnt0;
      send_frame(0, 8'h12, 1'b0, 1'b0, 40, -1, -1);
      cmp("brk_fe", 0, 32'(last_fe0), 32'd1);
      cmp("brk_one_dv", 0, 32'(dv_cnt0 - base_dv), 32'd1);
      idle(10);
      send_frame(0, 8'h55, 1'b0, 1'b1, 0, -1, -1);
      idle(20);
      cmp("after_brk_data", 0, 32'(last_data0), 32'h55);
      cmp("after_brk_fe", 0, 32'(last_fe0), 32'd0);

      // back-to-back, single-cycle glitch in centre of data bit 1 of 0xFE
      send_frame(0, 8'h01, 1'b0, 1'b1, 0, -1, -1);
      send_frame(0, 8'hFE, 1'b0, 1'b1, 0, 1, -1);
      idle(20);
      cmp("b2b_first", 0, 32'(prev_data0), 32'h01);
      cmp("b2b_second", 0, 32'(last_data0), 32'hFE);
      cmp("b2b_spacing", 0, 32'(last_dv_edge - prev_dv_edge), 32'd160);

      // reset during data bit 4 aborts the frame
      base_dv = dv_cnt0;
      send_frame(0, 8'h33, 1'b0, 1'b1, 0, -1, SR * 5 + 8);
      idle(10);
      send_frame(0, 8'h81, 1'b0, 1'b1, 0, -1, -1);
      idle(20);
      cmp("rst_abort_dv_count", 0, 32'(dv_cnt0 - base_dv), 32'd1);
      cmp("post_rst_data", 0, 32'(last_data0), 32'h81);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
